// File: rtl/change_dispenser.sv
// change_dispenser: queues dispense transactions from the vending FSM, actuates
// the purchased item over a valid/ready handshake, then pays the change one
// coin per handshake using greedy denominations 50/20/10/5/2/1.
module change_dispenser #(
   parameter  int MAX_ITEMS    = 1024,
   parameter  int MAX_NOTE_VAL = 100,
   parameter  int FIFO_DEPTH   = 4,
   localparam int IW           = $clog2(MAX_ITEMS),
   localparam int CW           = $clog2(MAX_NOTE_VAL) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          item_dispense_valid,
   input  logic [IW-1:0] item_dispense,
   input  logic [CW-1:0] currency_change,
   output logic          item_out_valid,
   output logic [IW-1:0] item_out,
   input  logic          item_out_ready,
   output logic          coin_valid,
   output logic [6:0]    coin_value,
   input  logic          coin_ready,
   output logic          txn_done,
   output logic [3:0]    txn_coin_count,
   output logic          busy,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, ITEM, COIN, DONE} state_t;

   state_t              state;
   logic [IW+CW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;
   logic [IW-1:0]       item_reg;
   logic [CW-1:0]       rem_reg;
   logic [3:0]          coin_cnt;

   logic                pop;
   logic                push_ok;
   logic [IW-1:0]       head_item;
   logic [CW-1:0]       head_change;
   logic [6:0]          cur_coin;
   logic [CW-1:0]       rem_next;
   logic [3:0]          cnt_next;

   // Largest denomination not exceeding the remaining change (0 when nothing is owed).
   function automatic logic [6:0] greedy_coin(input logic [CW-1:0] r);
      logic [31:0] rv;
      rv = 32'(r);
      if (rv >= 32'd50)      return 7'd50;
      else if (rv >= 32'd20) return 7'd20;
      else if (rv >= 32'd10) return 7'd10;
      else if (rv >= 32'd5)  return 7'd5;
      else if (rv >= 32'd2)  return 7'd2;
      else if (rv >= 32'd1)  return 7'd1;
      else                   return 7'd0;
   endfunction

   // Index 0 (coin return) and the top index (sold out) carry no item to actuate.
   function automatic logic is_sentinel(input logic [IW-1:0] it);
      return (it == '0) || (it == IW'(MAX_ITEMS - 1));
   endfunction

   assign pop         = (state == LOAD);
   assign push_ok     = item_dispense_valid &&
                        ((count < (AW+1)'(FIFO_DEPTH)) || pop);
   assign head_item   = mem[rd_ptr][IW+CW-1:CW];
   assign head_change = mem[rd_ptr][CW-1:0];
   assign cur_coin    = greedy_coin(rem_reg);
   assign rem_next    = rem_reg - CW'(cur_coin);
   assign cnt_next    = (coin_cnt == 4'd15) ? 4'd15 : coin_cnt + 4'd1;

   assign item_out    = item_out_valid ? item_reg : '0;
   assign coin_value  = coin_valid ? cur_coin : '0;
   assign busy        = (state != IDLE) || (count != '0);

   // Transaction storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {item_dispense, currency_change};
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (item_dispense_valid && !push_ok) overflow <= 1'b1;
      end
   end

   // Transaction sequencer: load, actuate item, pay coins, report completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         item_reg       <= '0;
         rem_reg        <= '0;
         coin_cnt       <= '0;
         item_out_valid <= 1'b0;
         coin_valid     <= 1'b0;
         txn_done       <= 1'b0;
         txn_coin_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               // An entry being pushed this cycle is already at the head by LOAD.
               if ((count != '0) || item_dispense_valid) state <= LOAD;
            end
            LOAD: begin
               item_reg <= head_item;
               rem_reg  <= head_change;
               coin_cnt <= '0;
               if (!is_sentinel(head_item)) begin
                  state          <= ITEM;
                  item_out_valid <= 1'b1;
               end else if (head_change != '0) begin
                  state      <= COIN;
                  coin_valid <= 1'b1;
               end else begin
                  state          <= DONE;
                  txn_done       <= 1'b1;
                  txn_coin_count <= '0;
               end
            end
            ITEM: begin
               if (item_out_ready) begin
                  item_out_valid <= 1'b0;
                  if (rem_reg != '0) begin
                     state      <= COIN;
                     coin_valid <= 1'b1;
                  end else begin
                     state          <= DONE;
                     txn_done       <= 1'b1;
                     txn_coin_count <= coin_cnt;
                  end
               end
            end
            COIN: begin
               if (coin_ready) begin
                  rem_reg  <= rem_next;
                  coin_cnt <= cnt_next;
                  if (rem_next == '0) begin
                     state          <= DONE;
                     coin_valid     <= 1'b0;
                     txn_done       <= 1'b1;
                     txn_coin_count <= cnt_next;
                  end
               end
            end
            DONE: begin
               state          <= IDLE;
               txn_done       <= 1'b0;
               txn_coin_count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes the expected event
// stream (item actuation, coins, completion) from a greedy change model; a
// monitor pops and compares on every handshake or completion pulse.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic       item_dispense_valid;
   logic [9:0] item_dispense;
   logic [7:0] currency_change;
   logic       item_out_valid;
   logic [9:0] item_out;
   logic       item_out_ready;
   logic       coin_valid;
   logic [6:0] coin_value;
   logic       coin_ready;
   logic       txn_done;
   logic [3:0] txn_coin_count;
   logic       busy;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   localparam int EV_ITEM = 1;
   localparam int EV_COIN = 2;
   localparam int EV_DONE = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t exp_q[$];

   change_dispenser dut (
      .clk                 (clk),
      .rst                 (rst),
      .item_dispense_valid (item_dispense_valid),
      .item_dispense       (item_dispense),
      .currency_change     (currency_change),
      .item_out_valid      (item_out_valid),
      .item_out            (item_out),
      .item_out_ready      (item_out_ready),
      .coin_valid          (coin_valid),
      .coin_value          (coin_value),
      .coin_ready          (coin_ready),
      .txn_done            (txn_done),
      .txn_coin_count      (txn_coin_count),
      .busy                (busy),
      .overflow            (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Expected events for one transaction, from the greedy change rule.
   function automatic void model_push(input int it, input int ch);
      int denoms[6] = '{50, 20, 10, 5, 2, 1};
      int r = ch;
      int n = 0;
      if (it != 0 && it != 1023) exp_q.push_back('{EV_ITEM, it});
      foreach (denoms[i]) begin
         while (r >= denoms[i]) begin
            exp_q.push_back('{EV_COIN, denoms[i]});
            r -= denoms[i];
            n++;
         end
      end
      exp_q.push_back('{EV_DONE, (n > 15) ? 15 : n});
   endfunction

   function automatic void mon_event(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: actual kind=%0d val=%0d required=none (t=%0t)",
                  kind, val, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_val", val, e.val);
      end
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (item_out_valid && item_out_ready) mon_event(EV_ITEM, int'(item_out));
         if (coin_valid && coin_ready)         mon_event(EV_COIN, int'(coin_value));
         if (txn_done)                         mon_event(EV_DONE, int'(txn_coin_count));
      end
   end

   // Called at posedge+1; returns at posedge+1 one cycle later.
   task automatic push(input int it, input int ch, input bit dropped);
      item_dispense_valid = 1'b1;
      item_dispense       = 10'(it);
      currency_change     = 8'(ch);
      if (!dropped) model_push(it, ch);
      @(posedge clk); #1;
      item_dispense_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm, input bit rnd);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!busy) break;
         @(posedge clk); #1;
         if (rnd) begin
            item_out_ready = 1'($urandom_range(0, 1));
            coin_ready     = 1'($urandom_range(0, 1));
         end
      end while (n < budget);
      chk(nm, int'(busy), 0);
      @(posedge clk); #1;
      item_out_ready = 1'b1;
      coin_ready     = 1'b1;
   endtask

   task automatic wait_coin(input int budget, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!coin_valid && n < budget);
      chk(nm, int'(coin_valid), 1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_item_out_valid"}, int'(item_out_valid), 0);
      chk({pfx, "_item_out"},       int'(item_out), 0);
      chk({pfx, "_coin_valid"},     int'(coin_valid), 0);
      chk({pfx, "_coin_value"},     int'(coin_value), 0);
      chk({pfx, "_txn_done"},       int'(txn_done), 0);
      chk({pfx, "_txn_coin_count"}, int'(txn_coin_count), 0);
      chk({pfx, "_busy"},           int'(busy), 0);
      chk({pfx, "_overflow"},       int'(overflow), 0);
   endtask

   initial begin
      rst                 = 1'b1;
      item_dispense_valid = 1'b0;
      item_dispense       = '0;
      currency_change     = '0;
      item_out_ready      = 1'b1;
      coin_ready          = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Item with no change; push, LOAD, then ITEM.
      push(5, 0, 1'b0);
      @(negedge clk);
      chk("lat_load_no_valid", int'(item_out_valid), 0);
      @(negedge clk);
      chk("lat_item_valid", int'(item_out_valid), 1);
      chk("lat_item_value", int'(item_out), 5);
      @(posedge clk); #1;
      wait_idle(50, "t1_idle", 1'b0);

      // Item plus multi-coin change.
      push(7, 87, 1'b0);
      wait_idle(50, "t2_idle", 1'b0);

      // Coin return and sold-out sentinel: coins only.
      push(0, 30, 1'b0);
      wait_idle(50, "t3_idle", 1'b0);
      push(1023, 13, 1'b0);
      wait_idle(50, "t4_idle", 1'b0);

      // Hopper stall: coin must stay presented unchanged.
      coin_ready = 1'b0;
      push(0, 50, 1'b0);
      wait_coin(20, "stall_coin_seen");
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         chk("stall_coin_valid", int'(coin_valid), 1);
         chk("stall_coin_value", int'(coin_value), 50);
      end
      @(posedge clk); #1;
      coin_ready = 1'b1;
      wait_idle(50, "stall_idle", 1'b0);

      // Overflow: actuator blocked, six consecutive pushes; the sixth is dropped.
      item_out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(11 + i, $urandom_range(0, 100), (i == 5));
      @(negedge clk);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_item_hold", int'(item_out), 11);
      repeat (5) @(negedge clk);
      chk("ovf_sticky", int'(overflow), 1);
      chk("ovf_item_still", int'(item_out), 11);
      @(posedge clk); #1;
      item_out_ready = 1'b1;
      wait_idle(500, "ovf_drain_idle", 1'b0);
      chk("ovf_after_drain", int'(overflow), 1);

      // Random pairs of back-to-back transactions with random handshakes.
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < 2; k++) begin
            int sel;
            int it;
            sel = $urandom_range(0, 3);
            it  = (sel == 0) ? 0 : (sel == 1) ? 1023 : $urandom_range(1, 1022);
            push(it, $urandom_range(0, 255), 1'b0);
         end
         wait_idle(600, "rand_idle", 1'b1);
      end
      chk("rand_queue_empty", exp_q.size(), 0);

      // Reset mid-payout aborts the transaction.
      coin_ready = 1'b0;
      push(0, 37, 1'b0);
      wait_coin(20, "abort_coin_seen");
      chk("abort_first_coin", int'(coin_value), 20);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk_all_zero("abort");
      @(posedge clk); #1;
      rst        = 1'b0;
      coin_ready = 1'b1;
      begin
         int seen = 0;
         repeat (10) begin
            @(negedge clk);
            if (coin_valid || busy) seen++;
         end
         chk("abort_no_activity", seen, 0);
      end
      chk("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
